sha256_msg_sched: RTL and testbench

SHA-256 message-schedule generator. It accepts one 512-bit padded message block as sixteen 32-bit big-endian words over a valid/ready stream, then emits the 64 schedule words W0..W63 over a second valid/ready stream. The schedule is built in a 16-entry circular buffer. It sits between the block loader and the compression-round datapath (Ch/Maj/Σ rounds) in the SHA engine and supplies one W_t per round.

---
 rtl/sha256_msg_sched.sv | 114 +++++++++++
 tb/tb_sha256_msg_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
// SHA-256 message-schedule generator. It takes one padded 512-bit block as
// sixteen 32-bit big-endian words, word 0 first. It then emits the 64
// schedule words W0..W63, one per accepted output handshake.
// The schedule lives in a 16-entry circular buffer. Once W_t (t >= 16) has
// been consumed, it overwrites W_{t-16}, because every later word only looks
// back 2, 7, 15 and 16 places.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     message word stream (in_data = M_i)
//   out_valid/out_ready   schedule word stream (out_data = W_t)
//   out_idx               t of the word currently on out_data
//   out_last              high while out_idx == ROUNDS-1
//
// WORDSIZE must be 32. The SHA-256 rotate and shift amounts are fixed.
module sha256_msg_sched #(
   parameter int WORDSIZE = 32,
   parameter int ROUNDS   = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORDSIZE-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORDSIZE-1:0] out_data,
   output logic [5:0]          out_idx,
   output logic                out_last
);

   localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

   typedef enum logic {LOAD, EMIT} state_t;

   state_t              state;
   logic [3:0]          load_cnt;
   logic [5:0]          t;
   logic [WORDSIZE-1:0] sched_buf [16];

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   // Circular-buffer taps for W_{t-2}, W_{t-7}, W_{t-15}. The 4-bit
   // subtraction wraps mod 16 by construction. W_{t-16} sits at t[3:0],
   // which is the slot that W_t will overwrite.
   logic [3:0]          idx2, idx7, idx15, idx16;
   logic [WORDSIZE-1:0] w_new;
   logic                t_ge16;

   always_comb begin
      idx2   = t[3:0] - 4'd2;
      idx7   = t[3:0] - 4'd7;
      idx15  = t[3:0] - 4'd15;
      idx16  = t[3:0];
      t_ge16 = (t[5:4] != 2'b00);
      w_new  = sig1(sched_buf[idx2]) + sched_buf[idx7]
             + sig0(sched_buf[idx15]) + sched_buf[idx16];
   end

   // The outputs come only from registered state. While a word is stalled,
   // out_data and out_idx therefore hold steady. out_ready never reaches
   // out_valid combinationally.
   assign out_data = t_ge16 ? w_new : sched_buf[idx16];
   assign out_idx  = t;
   assign out_last = out_valid && (t == T_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         load_cnt  <= 4'd0;
         t         <= 6'd0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         for (int i = 0; i < 16; i++) sched_buf[i] <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid && in_ready) begin
                  sched_buf[load_cnt] <= in_data;
                  load_cnt            <= load_cnt + 4'd1;  // wraps to 0 after word 15
                  if (load_cnt == 4'd15) begin
                     state     <= EMIT;
                     t         <= 6'd0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (out_valid && out_ready) begin
                  if (t_ge16) sched_buf[idx16] <= w_new;
                  if (t == T_LAST) begin
                     state     <= LOAD;
                     t         <= 6'd0;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                  end else begin
                     t <= t + 6'd1;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, out_last;
   logic [31:0] out_data;
   logic [5:0]  out_idx;

   sha256_msg_sched #(.WORDSIZE(32), .ROUNDS(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] blk [16];
   logic [31:0] exp_w [64];
   logic [31:0] got_d [64];
   int          got_i [64];
   logic        got_l [64];
   int          n_got, unstable, ready_in_emit;
   logic        first_valid, first_ready, load_timeout, collect_timeout;

   // Reference: the textbook 64-entry schedule expansion, no circular buffer.
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic void model();
      for (int k = 0; k < 16; k++) exp_w[k] = blk[k];
      for (int k = 16; k < 64; k++)
         exp_w[k] = (rotr(exp_w[k-2], 17) ^ rotr(exp_w[k-2], 19) ^ (exp_w[k-2] >> 10))
                  + exp_w[k-7]
                  + (rotr(exp_w[k-15], 7) ^ rotr(exp_w[k-15], 18) ^ (exp_w[k-15] >> 3))
                  + exp_w[k-16];
   endfunction

   function automatic void set_abc();
      for (int k = 0; k < 16; k++) blk[k] = 32'd0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
      model();
   endfunction

   function automatic void set_zero();
      for (int k = 0; k < 16; k++) blk[k] = 32'd0;
      model();
   endfunction

   // Drives the first `count` words of blk, with random in_valid gaps.
   // It returns after the last accepted word has been presented to the
   // rising edge that takes it.
   task automatic load_words(input int count, input int gap_pct);
      int i = 0;
      int cyc = 0;
      load_timeout = 1'b0;
      while (i < count) begin
         @(negedge clk);
         out_ready = 1'b0;
         if (cyc == 0) first_ready = in_ready;
         cyc++;
         if (cyc > 500) begin load_timeout = 1'b1; break; end
         if (int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end else begin
            in_valid = 1'b1;
            in_data  = blk[i];
            if (in_ready) i++;
         end
      end
   endtask

   // Accepts `count` output words with random backpressure. If stall16 is
   // set, it also holds out_ready low for 5 cycles while idx 16 is shown.
   // It records the accepted words and counts any change on a stalled output.
   task automatic collect(input int count, input int stall_pct, input bit stall16);
      int          cyc = 0;
      int          hold = 0;
      logic        have_prev = 1'b0;
      logic [31:0] pd = 32'd0;
      logic [5:0]  pidx = 6'd0;
      logic        rdy;
      n_got = 0; unstable = 0; ready_in_emit = 0; collect_timeout = 1'b0;
      while (n_got < count) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (cyc == 0) first_valid = out_valid;
         cyc++;
         if (cyc > 2000) begin collect_timeout = 1'b1; break; end
         if (out_valid && in_ready) ready_in_emit++;
         rdy = (int'($urandom_range(99)) >= stall_pct);
         if (stall16 && out_valid && out_idx == 6'd16 && hold < 5) begin
            rdy = 1'b0;
            hold++;
         end
         out_ready = rdy;
         if (out_valid) begin
            if (have_prev && (out_data !== pd || out_idx !== pidx)) unstable++;
            if (rdy) begin
               got_d[n_got] = out_data;
               got_i[n_got] = int'(out_idx);
               got_l[n_got] = out_last;
               n_got++;
               have_prev = 1'b0;
            end else begin
               have_prev = 1'b1;
               pd = out_data;
               pidx = out_idx;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 6'd0 ||
          out_last !== 1'b0 || out_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_vals: in_ready=%b out_valid=%b idx=%0d last=%b data=%h, want 1 0 0 0 0",
                  in_ready, out_valid, out_idx, out_last, out_data);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 6'd0) begin
            errors++;
            $display("FAIL idle_c%0d: in_ready=%b out_valid=%b idx=%0d, want 1 0 0",
                     c, in_ready, out_valid, out_idx);
         end
      end
   endtask

   task automatic test_abc();
      set_abc();
      load_words(16, 0);
      collect(64, 0, 1'b0);
      checks++;
      if (load_timeout || collect_timeout || n_got !== 64) begin
         errors++;
         $display("FAIL abc_count: got %0d words (timeouts %b %b), want 64",
                  n_got, load_timeout, collect_timeout);
      end
      checks++;
      if (first_ready !== 1'b1 || first_valid !== 1'b1) begin
         errors++;
         $display("FAIL abc_latency: in_ready@start=%b out_valid@1st=%b, want 1 1",
                  first_ready, first_valid);
      end
      checks++;
      if (got_d[16] !== 32'h61626380 || got_d[17] !== 32'h000F0000) begin
         errors++;
         $display("FAIL abc_w16_w17: got %h %h, want 61626380 000f0000", got_d[16], got_d[17]);
      end
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got_d[k] !== exp_w[k] || got_i[k] !== k || got_l[k] !== (k == 63)) begin
            errors++;
            $display("FAIL abc_w%0d: data=%h idx=%0d last=%b, want %h %0d %b",
                     k, got_d[k], got_i[k], got_l[k], exp_w[k], k, (k == 63));
         end
      end
      checks++;
      if (ready_in_emit !== 0) begin
         errors++;
         $display("FAIL abc_in_ready_emit: high for %0d cycles in EMIT, want 0", ready_in_emit);
      end
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL abc_return_load: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_zero();
      set_zero();
      load_words(16, 0);
      collect(64, 0, 1'b0);
      checks++;
      if (n_got !== 64 || collect_timeout) begin
         errors++;
         $display("FAIL zero_count: got %0d words, want 64", n_got);
      end
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got_d[k] !== 32'd0 || got_i[k] !== k) begin
            errors++;
            $display("FAIL zero_w%0d: data=%h idx=%0d, want 00000000 %0d", k, got_d[k], got_i[k], k);
         end
      end
   endtask

   task automatic test_backpressure();
      set_abc();
      load_words(16, 30);
      collect(64, 40, 1'b1);
      checks++;
      if (n_got !== 64 || load_timeout || collect_timeout) begin
         errors++;
         $display("FAIL bp_count: got %0d words, want 64", n_got);
      end
      checks++;
      if (unstable !== 0) begin
         errors++;
         $display("FAIL bp_stable: %0d changes while stalled, want 0", unstable);
      end
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got_d[k] !== exp_w[k] || got_i[k] !== k) begin
            errors++;
            $display("FAIL bp_w%0d: data=%h idx=%0d, want %h %0d", k, got_d[k], got_i[k], exp_w[k], k);
         end
      end
   endtask

   task automatic test_back_to_back();
      set_abc();
      load_words(16, 0);
      collect(64, 0, 1'b0);
      checks++;
      if (got_d[63] !== exp_w[63]) begin
         errors++;
         $display("FAIL b2b_first_w63: got %h want %h", got_d[63], exp_w[63]);
      end
      set_zero();
      load_words(16, 0);
      checks++;
      if (first_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_in_ready: got %b right after idx-63 handshake, want 1", first_ready);
      end
      collect(64, 0, 1'b0);
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got_d[k] !== 32'd0 || got_i[k] !== k) begin
            errors++;
            $display("FAIL b2b_w%0d: data=%h idx=%0d, want 00000000 %0d", k, got_d[k], got_i[k], k);
         end
      end
   endtask

   task automatic test_random_blocks();
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 16; k++) blk[k] = $urandom;
         model();
         load_words(16, 20);
         collect(64, 25, 1'b0);
         checks++;
         if (n_got !== 64 || unstable !== 0) begin
            errors++;
            $display("FAIL rnd%0d_flow: words=%0d unstable=%0d, want 64 0", b, n_got, unstable);
         end
         for (int k = 0; k < 64; k++) begin
            checks++;
            if (got_d[k] !== exp_w[k] || got_i[k] !== k) begin
               errors++;
               $display("FAIL rnd%0d_w%0d: data=%h idx=%0d, want %h %0d",
                        b, k, got_d[k], got_i[k], exp_w[k], k);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      // Abort the block at load_cnt = 9.
      set_zero();
      for (int k = 0; k < 16; k++) blk[k] = $urandom;
      load_words(9, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 6'd0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL rstload_vals: in_ready=%b out_valid=%b idx=%0d last=%b, want 1 0 0 0",
                  in_ready, out_valid, out_idx, out_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      set_abc();
      load_words(16, 0);
      collect(64, 0, 1'b0);
      checks++;
      if (got_d[16] !== 32'h61626380 || got_d[0] !== 32'h61626380) begin
         errors++;
         $display("FAIL rstload_abc: w0=%h w16=%h, want 61626380 61626380", got_d[0], got_d[16]);
      end
      // Abort the block at t = 40.
      load_words(16, 0);
      collect(40, 0, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 6'd40) begin
         errors++;
         $display("FAIL rstemit_pre: out_valid=%b idx=%0d, want 1 40", out_valid, out_idx);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 6'd0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL rstemit_vals: in_ready=%b out_valid=%b idx=%0d last=%b, want 1 0 0 0",
                  in_ready, out_valid, out_idx, out_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      load_words(16, 0);
      collect(64, 0, 1'b0);
      checks++;
      if (got_d[16] !== 32'h61626380 || got_d[63] !== exp_w[63]) begin
         errors++;
         $display("FAIL rstemit_abc: w16=%h w63=%h, want 61626380 %h", got_d[16], got_d[63], exp_w[63]);
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_abc();
      test_zero();
      test_backpressure();
      test_back_to_back();
      test_random_blocks();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
